// File: rtl/vga_pkg.sv
// Shared constants, the per-pixel side-band record and the character address
// helper used by the 80x30 text renderer.
package vga_pkg;

  localparam int H_ACTIVE       = 640;
  localparam int V_ACTIVE       = 480;
  localparam int GLYPH_W        = 8;
  localparam int GLYPH_H        = 16;
  localparam int DEF_TEXT_COLS  = 80;
  localparam int DEF_TEXT_ROWS  = 30;
  localparam int RENDER_LATENCY = 4;
  localparam int RGB_W          = 4;

  // The underline cursor occupies the bottom two scanlines of a glyph cell.
  localparam logic [3:0] CURSOR_LINE_A = 4'(GLYPH_H - 2);
  localparam logic [3:0] CURSOR_LINE_B = 4'(GLYPH_H - 1);

  typedef struct packed {
    logic       active;
    logic [2:0] hsub;
    logic [3:0] vsub;
    logic       cursor_hit;
    logic       hsync;
    logic       vsync;
  } side_t;

  localparam side_t SIDE_IDLE = '{active: 1'b0, hsub: 3'd0, vsub: 4'd0,
                                  cursor_hit: 1'b0, hsync: 1'b1, vsync: 1'b1};

  // row*80 + col built from shifts; the largest result is 2399.
  function automatic logic [11:0] char_addr(input logic [4:0] row, input logic [6:0] col);
    return (12'(row) << 6) + (12'(row) << 4) + 12'(col);
  endfunction

endpackage

// File: rtl/vga_text_render_if.sv
// Pin bundle between the timing generator, the character/font memories and
// the text renderer.
interface vga_text_render_if;
  // Streaming contract, no valid/ready: one pixel per CLK_25M cycle, CHAR_DATA
  // and FONT_DATA answer the address of the previous cycle, and every renderer
  // output lags the timing inputs by a fixed number of cycles.
  logic [9:0]  HCOUNT;
  logic [9:0]  VCOUNT;
  logic        HSYNC_IN;
  logic        VSYNC_IN;
  logic [11:0] CHAR_ADDR;
  logic [7:0]  CHAR_DATA;
  logic [10:0] FONT_ADDR;
  logic [7:0]  FONT_DATA;
  logic [11:0] FG_COLOR;
  logic [11:0] BG_COLOR;
  logic        CURSOR_EN;
  logic [6:0]  CURSOR_COL;
  logic [4:0]  CURSOR_ROW;
  logic [vga_pkg::RGB_W-1:0] VGA_R;
  logic [vga_pkg::RGB_W-1:0] VGA_G;
  logic [vga_pkg::RGB_W-1:0] VGA_B;
  logic        VGA_HSYNC;
  logic        VGA_VSYNC;

  modport master (
    output HCOUNT, VCOUNT, HSYNC_IN, VSYNC_IN, CHAR_DATA, FONT_DATA,
           FG_COLOR, BG_COLOR, CURSOR_EN, CURSOR_COL, CURSOR_ROW,
    input  CHAR_ADDR, FONT_ADDR, VGA_R, VGA_G, VGA_B, VGA_HSYNC, VGA_VSYNC
  );

  modport slave (
    input  HCOUNT, VCOUNT, HSYNC_IN, VSYNC_IN, CHAR_DATA, FONT_DATA,
           FG_COLOR, BG_COLOR, CURSOR_EN, CURSOR_COL, CURSOR_ROW,
    output CHAR_ADDR, FONT_ADDR, VGA_R, VGA_G, VGA_B, VGA_HSYNC, VGA_VSYNC
  );

endinterface

// File: rtl/vga_blink_timer.sv
// Counts VSYNC falling edges and toggles the cursor blink phase every
// BLINK_FRAMES frames.
module vga_blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic CLK_25M,
  input  logic RST,
  input  logic VSYNC_IN,
  output logic o_phase
);

  logic       r_vsync_prev;
  logic [5:0] r_frame_cnt;
  logic       r_phase;
  logic       w_vsync_fall;

  assign w_vsync_fall = r_vsync_prev && !VSYNC_IN;

  always_ff @(posedge CLK_25M) begin
    if (RST) begin
      r_vsync_prev <= 1'b0;
      r_frame_cnt  <= '0;
      r_phase      <= 1'b0;
    end else begin
      r_vsync_prev <= VSYNC_IN;
      if (w_vsync_fall) begin
        if (r_frame_cnt == 6'(BLINK_FRAMES - 1)) begin
          r_frame_cnt <= '0;
          r_phase     <= ~r_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + 6'd1;
        end
      end
    end
  end

  assign o_phase = r_phase;

endmodule

// File: rtl/vga_text_render.sv
// 80x30 text-mode pixel source: character RAM -> font ROM -> colour select,
// with syncs and side-band info carried alongside in a fixed-latency pipeline.
module vga_text_render
  import vga_pkg::*;
#(
  parameter int BLINK_FRAMES = 30,
  parameter int TEXT_COLS    = DEF_TEXT_COLS,
  parameter int TEXT_ROWS    = DEF_TEXT_ROWS
) (
  input logic              CLK_25M,
  input logic              RST,
  vga_text_render_if.slave bus
);

  logic        w_phase;
  logic        w_active;
  logic        w_cursor_hit;
  logic [6:0]  w_col;
  logic [4:0]  w_row;
  logic [2:0]  w_bit_sel;
  logic        w_pix;
  side_t       w_side0;

  side_t       r_side [1:RENDER_LATENCY];
  logic [11:0] r_char_addr;
  logic [10:0] r_font_addr;
  logic        r_inv;
  logic        r_inv_d;
  logic [11:0] r_rgb;
  logic        r_hsync;
  logic        r_vsync;

  vga_blink_timer #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
    .CLK_25M (CLK_25M),
    .RST     (RST),
    .VSYNC_IN(bus.VSYNC_IN),
    .o_phase (w_phase)
  );

  assign w_col    = bus.HCOUNT[9:3];
  assign w_row    = bus.VCOUNT[8:4];
  assign w_active = (bus.HCOUNT < 10'(H_ACTIVE)) && (bus.VCOUNT < 10'(V_ACTIVE));

  // Cursor is resolved at stage 0 and then rides the pipeline as one bit.
  assign w_cursor_hit = bus.CURSOR_EN && w_phase && w_active
                     && (bus.CURSOR_COL < 7'(TEXT_COLS)) && (bus.CURSOR_ROW < 5'(TEXT_ROWS))
                     && (w_col == bus.CURSOR_COL) && (w_row == bus.CURSOR_ROW)
                     && ((bus.VCOUNT[3:0] == CURSOR_LINE_A) || (bus.VCOUNT[3:0] == CURSOR_LINE_B));

  assign w_side0 = '{active: w_active, hsub: bus.HCOUNT[2:0], vsub: bus.VCOUNT[3:0],
                     cursor_hit: w_cursor_hit, hsync: bus.HSYNC_IN, vsync: bus.VSYNC_IN};

  assign w_bit_sel = 3'(GLYPH_W - 1) - r_side[RENDER_LATENCY].hsub;
  assign w_pix     = (bus.FONT_DATA[w_bit_sel] ^ r_inv_d) | r_side[RENDER_LATENCY].cursor_hit;

  always_ff @(posedge CLK_25M) begin
    if (RST) begin
      for (int i = 1; i <= RENDER_LATENCY; i++) r_side[i] <= SIDE_IDLE;
      r_char_addr <= '0;
      r_font_addr <= '0;
      r_inv       <= 1'b0;
      r_inv_d     <= 1'b0;
      r_rgb       <= '0;
      r_hsync     <= 1'b1;
      r_vsync     <= 1'b1;
    end else begin
      r_side[1] <= w_side0;
      for (int i = 2; i <= RENDER_LATENCY; i++) r_side[i] <= r_side[i-1];
      if (w_active) r_char_addr <= char_addr(w_row, w_col);
      // r_side[2] holds the scanline of the pixel whose CHAR_DATA is arriving now.
      r_font_addr <= {bus.CHAR_DATA[6:0], r_side[2].vsub};
      r_inv       <= bus.CHAR_DATA[7];
      r_inv_d     <= r_inv;
      r_rgb       <= r_side[RENDER_LATENCY].active ? (w_pix ? bus.FG_COLOR : bus.BG_COLOR) : '0;
      r_hsync     <= r_side[RENDER_LATENCY].hsync;
      r_vsync     <= r_side[RENDER_LATENCY].vsync;
    end
  end

  assign bus.CHAR_ADDR = r_char_addr;
  assign bus.FONT_ADDR = r_font_addr;
  assign bus.VGA_R     = r_rgb[11:8];
  assign bus.VGA_G     = r_rgb[7:4];
  assign bus.VGA_B     = r_rgb[3:0];
  assign bus.VGA_HSYNC = r_hsync;
  assign bus.VGA_VSYNC = r_vsync;

endmodule

// File: tb/tb_vga_text_render.sv
// Bench for vga_text_render: streams pixels through the renderer and compares
// against a screen-level model of the text display built from RAM/ROM arrays.
module tb_vga_text_render;

  localparam int BLINK = 2;
  localparam int MAXN  = 512;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #20 clk = ~clk;

  vga_text_render_if bus();

  vga_text_render #(.BLINK_FRAMES(BLINK)) dut (
    .CLK_25M(clk),
    .RST    (rst),
    .bus    (bus)
  );

  // Synchronous memories: data one cycle after address.
  logic [7:0] char_ram [0:4095];
  logic [7:0] font_rom [0:2047];
  always @(posedge clk) begin
    bus.CHAR_DATA <= char_ram[bus.CHAR_ADDR];
    bus.FONT_DATA <= font_rom[bus.FONT_ADDR];
  end

  // ---------------- bench state ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [11:0] fg, bg;
  logic        cur_en;
  int          cur_col, cur_row;
  int          falls;
  logic        vs_last;

  int          st_h [MAXN];
  int          st_v [MAXN];
  logic        st_hs [MAXN];
  logic        st_vs [MAXN];
  logic        st_ph [MAXN];
  logic [11:0] sn_rgb [MAXN+4];
  logic [11:0] sn_ca  [MAXN+4];
  logic [10:0] sn_fa  [MAXN+4];
  logic        sn_hs  [MAXN+4];
  logic        sn_vs  [MAXN+4];

  // ---------------- reference model ----------------
  function automatic logic [11:0] model_rgb(input int h, input int v, input logic ph);
    logic [7:0] code;
    logic [7:0] bits;
    logic       pix;
    if (h >= 640 || v >= 480) return 12'h000;
    code = char_ram[(v / 16) * 80 + h / 8];
    bits = font_rom[int'(code[6:0]) * 16 + v % 16];
    pix  = bits[7 - h % 8] ^ code[7];
    if (cur_en && ph && (h / 8 == cur_col) && (v / 16 == cur_row) && (v % 16 >= 14)) pix = 1'b1;
    return pix ? fg : bg;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_inputs(input int h, input int v, input logic hs, input logic vs);
    bus.HCOUNT     = 10'(h);
    bus.VCOUNT     = 10'(v);
    bus.HSYNC_IN   = hs;
    bus.VSYNC_IN   = vs;
    bus.FG_COLOR   = fg;
    bus.BG_COLOR   = bg;
    bus.CURSOR_EN  = cur_en;
    bus.CURSOR_COL = 7'(cur_col);
    bus.CURSOR_ROW = 5'(cur_row);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    drive_inputs(700, 500, 1'b1, 1'b1);
    repeat (n) @(posedge clk);
    #1;
    rst     = 1'b0;
    falls   = 0;
    vs_last = 1'b0;
  endtask

  // Drives st_*[0..n-1] one per cycle, then 4 blank cycles; snapshot c is taken
  // 1 time unit after the edge that samples stimulus c.
  task automatic stream(input int n);
    for (int c = 0; c < n + 4; c++) begin
      if (c < n) begin
        st_ph[c] = ((falls / BLINK) % 2) == 1;
        if (vs_last && !st_vs[c]) falls++;
        vs_last = st_vs[c];
        drive_inputs(st_h[c], st_v[c], st_hs[c], st_vs[c]);
      end else begin
        vs_last = 1'b1;
        drive_inputs(700, 500, 1'b1, 1'b1);
      end
      @(posedge clk);
      #1;
      sn_rgb[c] = {bus.VGA_R, bus.VGA_G, bus.VGA_B};
      sn_ca[c]  = bus.CHAR_ADDR;
      sn_fa[c]  = bus.FONT_ADDR;
      sn_hs[c]  = bus.VGA_HSYNC;
      sn_vs[c]  = bus.VGA_VSYNC;
    end
  endtask

  task automatic set_stim(input int i, input int h, input int v, input logic hs, input logic vs);
    st_h[i]  = h;
    st_v[i]  = v;
    st_hs[i] = hs;
    st_vs[i] = vs;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [11:0] exp;
    fg = 12'hFFF; bg = 12'hFFF; cur_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_inputs(8 * i + 8, 5, 1'b0, 1'b0);
      @(posedge clk);
      #1;
    end
    n_checks++;
    if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 12'hFFF || bus.VGA_HSYNC !== 1'b0)
      $display("FAIL pre_reset: rgb=%h hs=%b expected rgb=fff hs=0", {bus.VGA_R, bus.VGA_G, bus.VGA_B}, bus.VGA_HSYNC);
    else n_pass++;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_inputs(56 + 8 * i, 5, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      n_checks++;
      if ({bus.VGA_R, bus.VGA_G, bus.VGA_B} !== 12'h000 || bus.VGA_HSYNC !== 1'b1 || bus.VGA_VSYNC !== 1'b1 ||
          bus.CHAR_ADDR !== 12'd0 || bus.FONT_ADDR !== 11'd0)
        $display("FAIL reset_cycle%0d: rgb=%h hs=%b vs=%b ca=%0d fa=%0d expected 000/1/1/0/0", i,
                 {bus.VGA_R, bus.VGA_G, bus.VGA_B}, bus.VGA_HSYNC, bus.VGA_VSYNC, bus.CHAR_ADDR, bus.FONT_ADDR);
      else n_pass++;
    end
    rst = 1'b0; falls = 0; vs_last = 1'b0;
    fg = 12'h9C3; bg = 12'h14E;
    set_stim(0, 24, 40, 1'b1, 1'b1);
    stream(1);
    exp = model_rgb(24, 40, st_ph[0]);
    n_checks++;
    if (sn_rgb[4] !== exp) $display("FAIL post_reset_pixel: got %h expected %h", sn_rgb[4], exp);
    else n_pass++;
  endtask

  task automatic test_latency();
    logic [11:0] exp;
    char_ram[0] = 8'h41; font_rom[11'h410] = 8'h80;
    fg = 12'hFFF; bg = 12'h000; cur_en = 1'b0;
    for (int i = 0; i < 8; i++) set_stim(i, i, 0, 1'b1, 1'b1);
    stream(8);
    n_checks++;
    if (sn_rgb[3] !== 12'h000) $display("FAIL latency_early: got %h expected 000", sn_rgb[3]);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      exp = model_rgb(i, 0, st_ph[i]);
      n_checks++;
      if (sn_rgb[i + 4] !== exp) $display("FAIL latency_px%0d: got %h expected %h", i, sn_rgb[i + 4], exp);
      else n_pass++;
    end
  endtask

  task automatic test_addressing();
    int last_ca;
    int exp_fa;
    char_ram[82] = 8'h41;
    set_stim(0, 8, 16, 1'b1, 1'b1);
    set_stim(1, 639, 479, 1'b1, 1'b1);
    set_stim(2, 700, 479, 1'b1, 1'b1);
    set_stim(3, 16, 21, 1'b1, 1'b1);
    stream(4);
    last_ca = 0;
    for (int c = 0; c < 4; c++) begin
      if (st_h[c] < 640 && st_v[c] < 480) last_ca = (st_v[c] / 16) * 80 + st_h[c] / 8;
      exp_fa = int'(char_ram[last_ca][6:0]) * 16 + st_v[c] % 16;
      n_checks++;
      if (sn_ca[c] !== 12'(last_ca)) $display("FAIL char_addr%0d: got %0d expected %0d", c, sn_ca[c], last_ca);
      else n_pass++;
      n_checks++;
      if (sn_fa[c + 2] !== 11'(exp_fa)) $display("FAIL font_addr%0d: got %h expected %h", c, sn_fa[c + 2], exp_fa);
      else n_pass++;
    end
  endtask

  task automatic test_blanking();
    fg = 12'hFFF; bg = 12'hFFF; cur_en = 1'b0;
    for (int i = 0; i < 160; i++) set_stim(i, 640 + i, 100, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) set_stim(160 + i, $urandom_range(0, 639), 480 + i, 1'b1, 1'b1);
    stream(200);
    for (int c = 0; c < 200; c++) begin
      n_checks++;
      if (sn_rgb[c + 4] !== 12'h000) $display("FAIL blank h=%0d v=%0d: got %h expected 000", st_h[c], st_v[c], sn_rgb[c + 4]);
      else n_pass++;
    end
  endtask

  task automatic test_sync_align();
    logic [7:0] hs_pat;
    logic [7:0] vs_pat;
    hs_pat = 8'b1110_0011;
    vs_pat = 8'b1100_0111;
    for (int i = 0; i < 8; i++) set_stim(i, 700, 490, hs_pat[i], vs_pat[i]);
    stream(8);
    for (int c = 0; c < 8; c++) begin
      n_checks++;
      if (sn_hs[c + 4] !== st_hs[c] || sn_vs[c + 4] !== st_vs[c])
        $display("FAIL sync%0d: got hs=%b vs=%b expected hs=%b vs=%b", c, sn_hs[c + 4], sn_vs[c + 4], st_hs[c], st_vs[c]);
      else n_pass++;
    end
  endtask

  task automatic test_inverse();
    logic [11:0] exp;
    char_ram[160] = 8'hC1; font_rom[11'h410] = 8'h80;
    fg = 12'hA5C; bg = 12'h351; cur_en = 1'b0;
    for (int i = 0; i < 8; i++) set_stim(i, i, 32, 1'b1, 1'b1);
    stream(8);
    for (int i = 0; i < 8; i++) begin
      exp = model_rgb(i, 32, st_ph[i]);
      n_checks++;
      if (sn_rgb[i + 4] !== exp) $display("FAIL inverse_px%0d: got %h expected %h", i, sn_rgb[i + 4], exp);
      else n_pass++;
    end
  endtask

  task automatic test_cursor_blink();
    logic [11:0] exp;
    int          n;
    do_reset(2);
    fg = 12'h0F0; bg = 12'h00F; cur_en = 1'b1; cur_col = 5; cur_row = 3;
    char_ram[245] = 8'h00; char_ram[246] = 8'h00;
    for (int r = 0; r < 16; r++) font_rom[r] = 8'h00;
    for (int p = 0; p < 5; p++) begin
      if (p > 0) begin
        set_stim(0, 700, 490, 1'b1, 1'b0);
        set_stim(1, 700, 490, 1'b1, 1'b0);
        set_stim(2, 700, 490, 1'b1, 1'b1);
        stream(3);
      end
      n = 0;
      for (int v = 61; v <= 63; v++)
        for (int h = 40; h <= 48; h++) begin
          set_stim(n, h, v, 1'b1, 1'b1);
          n++;
        end
      stream(n);
      for (int c = 0; c < n; c++) begin
        exp = model_rgb(st_h[c], st_v[c], st_ph[c]);
        n_checks++;
        if (sn_rgb[c + 4] !== exp)
          $display("FAIL cursor falls=%0d h=%0d v=%0d: got %h expected %h", p, st_h[c], st_v[c], sn_rgb[c + 4], exp);
        else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] exp;
    fg = 12'($urandom); bg = 12'($urandom);
    cur_en = 1'b1; cur_col = $urandom_range(0, 79); cur_row = $urandom_range(0, 29);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0)
        set_stim(i, cur_col * 8 + $urandom_range(0, 7), cur_row * 16 + $urandom_range(13, 15),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
      else
        set_stim(i, $urandom_range(0, 799), $urandom_range(0, 524),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    end
    stream(300);
    for (int c = 0; c < 300; c++) begin
      exp = model_rgb(st_h[c], st_v[c], st_ph[c]);
      n_checks++;
      if (sn_rgb[c + 4] !== exp || sn_hs[c + 4] !== st_hs[c] || sn_vs[c + 4] !== st_vs[c])
        $display("FAIL random%0d h=%0d v=%0d: got rgb=%h hs=%b vs=%b expected rgb=%h hs=%b vs=%b", c, st_h[c], st_v[c],
                 sn_rgb[c + 4], sn_hs[c + 4], sn_vs[c + 4], exp, st_hs[c], st_vs[c]);
      else n_pass++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    fg = 12'h000; bg = 12'h000; cur_en = 1'b0; cur_col = 0; cur_row = 0;
    falls = 0; vs_last = 1'b1; rst = 1'b1;
    for (int i = 0; i < 4096; i++) char_ram[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) font_rom[i] = 8'($urandom);
    drive_inputs(700, 500, 1'b1, 1'b1);
    do_reset(2);
    test_reset();
    test_latency();
    test_addressing();
    test_blanking();
    test_sync_align();
    test_inverse();
    test_cursor_blink();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_text_render.md
Name: vga_text_render

Overview:
- Pixel-source stage feeding the VGA output pins. Consumes the pixel-clock timing counters and raw syncs from the 640x480 timing generator and renders an 80x30 text screen from 8x16 glyphs.
- Fetches character codes from an external synchronous character RAM and glyph rows from an external synchronous font ROM. Overlays a blinking underline cursor.
- Delays HSYNC/VSYNC to stay aligned with the pixel pipeline.

Parameters:
- BLINK_FRAMES, 30, frames per cursor blink phase (range 1..63)
- TEXT_COLS, 80, characters per line
- TEXT_ROWS, 30, character lines per screen

Ports:
- CLK_25M  input  1  pixel clock, all logic on rising edge
- RST  input  1  synchronous, active-high reset
- HCOUNT  input  10  horizontal pixel counter from timing generator (0..799)
- VCOUNT  input  10  vertical line counter from timing generator (0..524)
- HSYNC_IN  input  1  raw horizontal sync, active low
- VSYNC_IN  input  1  raw vertical sync, active low
- CHAR_ADDR  output  12  character RAM read address
- CHAR_DATA  input  8  character RAM data, valid 1 cycle after CHAR_ADDR; bit7 = inverse video, [6:0] = glyph code
- FONT_ADDR  output  11  font ROM address {code[6:0], glyph_row[3:0]}
- FONT_DATA  input  8  font ROM row, valid 1 cycle after FONT_ADDR; bit7 = leftmost pixel
- FG_COLOR  input  12  foreground {R,G,B} 4 bits each
- BG_COLOR  input  12  background {R,G,B}
- CURSOR_EN  input  1  cursor enable
- CURSOR_COL  input  7  cursor column 0..79
- CURSOR_ROW  input  5  cursor row 0..29
- VGA_R / VGA_G / VGA_B  output  4 each  pixel colour
- VGA_HSYNC / VGA_VSYNC  output  1 each  delayed syncs, active low

Behaviour:
- Reset (RST=1 at an edge):
  - All pipeline registers cleared; CHAR_ADDR=0, FONT_ADDR=0.
  - VGA_R/G/B=0; VGA_HSYNC=VGA_VSYNC=1.
  - Frame counter=0, blink phase=0.
  - Reset mid-frame takes effect at the next edge. Output is valid again 4 cycles after RST drops.
- Stage 0 (edge k): sample HCOUNT/VCOUNT/syncs.
  - active = HCOUNT<640 && VCOUNT<480.
  - col = HCOUNT[9:3], row = VCOUNT[8:4].
  - CHAR_ADDR <= row*80 + col, computed as (row<<6)+(row<<4)+col, 12-bit, no overflow (max 2399).
  - Outside active, CHAR_ADDR holds its last value.
- Edge k+1: RAM presents CHAR_DATA.
- Edge k+2: FONT_ADDR <= {CHAR_DATA[6:0], VCOUNT[3:0] delayed}; inverse bit registered.
- Edge k+3: ROM presents FONT_DATA.
- Edge k+4: colour selection.
  - pix = FONT_DATA[7 - HCOUNT[2:0] delayed].
  - pix ^= inverse.
  - pix |= cursor_hit, where cursor_hit = CURSOR_EN && blink phase==1 && col==CURSOR_COL && row==CURSOR_ROW && glyph_row in {14,15}.
  - RGB <= active_d ? (pix ? FG_COLOR : BG_COLOR) : 0.
- Latency: fixed 4 cycles, inputs to all of RGB/HSYNC/VSYNC. Syncs pass through 4 registers unmodified.
- All per-pixel side info (active, HCOUNT[2:0], VCOUNT[3:0], col, row) is delayed in lockstep with the data pipeline.
- Blink:
  - A falling edge of VSYNC_IN (registered previous value 1, current 0) increments the frame counter.
  - When counter == BLINK_FRAMES-1: counter <= 0 and phase toggles.
  - Falling edge coincident with RST: RST wins.
- FG_COLOR/BG_COLOR/CURSOR_* are sampled at stage 0 (cursor) or stage 4 (colours). Changes mid-line take effect per pixel, no glitch protection required.
- Out-of-range cursor (col>79 or row>29) never matches; no error.

Decomposition:
- Package vga_pkg: H_ACTIVE=640, V_ACTIVE=480, GLYPH_W=8, GLYPH_H=16, TEXT_COLS/ROWS defaults, RENDER_LATENCY=4, RGB width constant 4, cursor underline rows 14/15.
- Sub-module vga_blink_timer: VSYNC falling-edge detect, frame counter, phase output. CLK_25M/RST/VSYNC_IN/BLINK_FRAMES in, phase out.

Test Plan:
- Reset: hold RST 3 cycles mid-line.
  - Required: RGB=0, VGA_HSYNC=VGA_VSYNC=1, CHAR_ADDR=0, FONT_ADDR=0 at the first edge of reset.
- Latency/pixel order:
  - Stimulus: RAM model returns 0x41 at addr 0; ROM row {0x41,0} = 0x80; FG=0xFFF, BG=0x000; drive HCOUNT=0..7, VCOUNT=0.
  - Required: 4 cycles later RGB=F,F,F for pixel 0 and 0,0,0 for pixels 1..7.
- Addressing:
  - HCOUNT=8, VCOUNT=16 gives CHAR_ADDR=81 one cycle later.
  - HCOUNT=639, VCOUNT=479 gives CHAR_ADDR=2399.
  - FONT_ADDR for code 0x41 at VCOUNT=21 is 0x415.
- Blanking and sync alignment:
  - HCOUNT=640..799 gives RGB=0 regardless of font data.
  - HSYNC_IN falling at edge k gives VGA_HSYNC falling after edge k+4; same for VSYNC.
- Inverse video: CHAR_DATA=0xC1 with font row 0x80 gives pixel 0 = BG and pixels 1..7 = FG.
- Cursor blink:
  - Stimulus: BLINK_FRAMES=2, CURSOR_EN=1, cursor (5,3), blank glyph.
  - Required: no underline before the 2nd VSYNC_IN falling edge. After it, lines 62,63 at HCOUNT 40..47 show FG. After the 4th edge the underline disappears.
